// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with valid/ready byte output.
// Ports: clk, rst (sync, active-low), rx (async line), data/valid/ready
// (byte handshake), frame_err/overrun (1-cycle pulses), busy (not idle).
module uart_rx #(
    parameter int CLK_HZ       = 48000000,
    parameter int BAUD         = 115200,
    parameter int CLKS_PER_BIT = CLK_HZ / BAUD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int HALF = CLKS_PER_BIT / 2;
    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t        state;
    logic          sync1;
    logic          rx_s;
    logic [7:0]    shift;
    logic [2:0]    bit_idx;
    logic [CW-1:0] cnt;
    logic          load;

    // Receive FSM. The shift register is not touched again until the
    // next frame's first data sample, so the output stage can read it
    // one cycle after the registered load strobe.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            sync1     <= 1'b1;
            rx_s      <= 1'b1;
            shift     <= 8'd0;
            bit_idx   <= 3'd0;
            cnt       <= '0;
            load      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            sync1     <= rx;
            rx_s      <= sync1;
            load      <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end
                START: begin
                    if (cnt == HALF_M1) begin
                        cnt     <= '0;
                        bit_idx <= 3'd0;
                        // A start bit gone high by its centre is a glitch.
                        state   <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == FULL_M1) begin
                        cnt     <= '0;
                        shift   <= {rx_s, shift[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == FULL_M1) begin
                        cnt <= '0;
                        if (rx_s) begin
                            load  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= WAIT_HIGH;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_HIGH: begin
                    // A held-low line (break) must not look like a start.
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Output handshake; a load wins over a same-cycle consume.
    always_ff @(posedge clk) begin
        if (!rst) begin
            data    <= 8'd0;
            valid   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (load) begin
                data    <= shift;
                valid   <= 1'b1;
                overrun <= valid && !ready;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized and directed bench for uart_rx.
// Bytes are framed by a bit-level sender; a queue model predicts output.
`timescale 1ns/1ps
module tb_uart_rx;
    localparam int CPB  = 416;
    localparam int HALF = CPB / 2;
    localparam int LAT  = 2 + HALF + 9 * CPB + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx = 1'b1;
    logic       ready = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int passed = 0;
    int total = 0;
    int cyc = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int vhi_cnt = 0;
    int rise_cyc = -1;
    int fall_busy = -1;
    logic valid_d = 1'b0;
    logic busy_d = 1'b0;
    logic [7:0] got_q[$];

    // Reference model: a one-entry holding slot seen from the consumer.
    logic [7:0] m_data = 8'd0;
    logic       m_valid = 1'b0;
    int         m_ov = 0;
    logic [7:0] m_q[$];

    uart_rx #(
        .CLK_HZ(48000000),
        .BAUD(115200)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx(rx),
        .data(data),
        .valid(valid),
        .ready(ready),
        .frame_err(frame_err),
        .overrun(overrun),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (frame_err) fe_cnt++;
        if (overrun) ov_cnt++;
        if (valid) vhi_cnt++;
        if (valid && ready) got_q.push_back(data);
        if (valid && !valid_d) rise_cyc = cyc;
        if (!busy && busy_d) fall_busy = cyc;
        valid_d = valid;
        busy_d = busy;
    end

    function automatic void m_set_ready(input logic r);
        if (r && m_valid) begin
            m_q.push_back(m_data);
            m_valid = 1'b0;
        end
    endfunction

    function automatic void m_frame(input logic [7:0] b, input logic r);
        if (r) begin
            m_q.push_back(b);
        end else begin
            if (m_valid) m_ov++;
            m_valid = 1'b1;
        end
        m_data = b;
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        fe_cnt = 0;
        ov_cnt = 0;
        vhi_cnt = 0;
        rise_cyc = -1;
        fall_busy = -1;
        got_q.delete();
        m_q.delete();
        m_ov = 0;
    endtask

    task automatic send_frame(input logic [7:0] b, input int cpb,
                              input logic stop_bit);
        logic [7:0] v;
        v = b;
        rx = 1'b0;
        wait_clk(cpb);
        for (int i = 0; i < 8; i++) begin
            rx = v[i];
            wait_clk(cpb);
        end
        rx = stop_bit;
        wait_clk(cpb);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        rx = 1'b1;
        wait_clk(3);
        total++; if (data !== 8'h00) $display("FAIL reset_data got %0h exp 0", data); else passed++;
        total++; if (valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", valid); else passed++;
        total++; if (frame_err !== 1'b0) $display("FAIL reset_ferr got %b exp 0", frame_err); else passed++;
        total++; if (overrun !== 1'b0) $display("FAIL reset_ovr got %b exp 0", overrun); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else passed++;
        rst = 1'b1;
        wait_clk(4);
    endtask

    task automatic test_single();
        int c;
        int lat;
        clear_mon();
        ready = 1'b1;
        m_set_ready(1'b1);
        c = cyc;
        send_frame(8'hA5, CPB, 1'b1);
        m_frame(8'hA5, 1'b1);
        wait_clk(CPB);
        lat = rise_cyc - (c + 1);
        total++; if (got_q.size() !== m_q.size()) $display("FAIL single_count got %0d exp %0d", got_q.size(), m_q.size()); else passed++;
        total++; if (got_q.size() > 0 && got_q[0] !== m_q[0]) $display("FAIL single_data got %0h exp %0h", got_q[0], m_q[0]); else passed++;
        total++; if (vhi_cnt != 1) $display("FAIL single_vwidth got %0d exp 1", vhi_cnt); else passed++;
        total++; if (rise_cyc < 0 || lat < LAT - 1 || lat > LAT + 1) $display("FAIL single_latency got %0d exp %0d", lat, LAT); else passed++;
        total++; if (fe_cnt != 0 || ov_cnt != 0) $display("FAIL single_flags got fe=%0d ov=%0d exp 0 0", fe_cnt, ov_cnt); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] seq [3];
        seq[0] = 8'h00;
        seq[1] = 8'hFF;
        seq[2] = 8'h55;
        clear_mon();
        ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send_frame(seq[i], CPB, 1'b1);
            m_frame(seq[i], 1'b0);
        end
        wait_clk(CPB);
        total++; if (ov_cnt != m_ov) $display("FAIL b2b_overrun got %0d exp %0d", ov_cnt, m_ov); else passed++;
        total++; if (valid !== m_valid) $display("FAIL b2b_valid got %b exp %b", valid, m_valid); else passed++;
        total++; if (data !== m_data) $display("FAIL b2b_data got %0h exp %0h", data, m_data); else passed++;
        ready = 1'b1;
        m_set_ready(1'b1);
        wait_clk(1);
        ready = 1'b0;
        wait_clk(1);
        total++; if (valid !== m_valid) $display("FAIL b2b_consume got %b exp %b", valid, m_valid); else passed++;
        total++; if (got_q.size() != 1 || got_q[0] !== m_q[0]) $display("FAIL b2b_popped got n=%0d exp %0h", got_q.size(), m_q[0]); else passed++;
    endtask

    task automatic test_frame_err();
        clear_mon();
        ready = 1'b1;
        m_set_ready(1'b1);
        send_frame(8'h3C, CPB, 1'b0);
        wait_clk(2000);
        total++; if (fe_cnt != 1) $display("FAIL ferr_pulse got %0d exp 1", fe_cnt); else passed++;
        total++; if (valid !== 1'b0 || got_q.size() != 0) $display("FAIL ferr_novalid got v=%b n=%0d exp 0 0", valid, got_q.size()); else passed++;
        total++; if (busy !== 1'b1) $display("FAIL ferr_busy got %b exp 1", busy); else passed++;
        rx = 1'b1;
        wait_clk(5);
        total++; if (busy !== 1'b0) $display("FAIL ferr_release got %b exp 0", busy); else passed++;
        send_frame(8'h81, CPB, 1'b1);
        m_frame(8'h81, 1'b1);
        wait_clk(CPB);
        total++; if (got_q.size() != 1 || got_q[0] !== m_q[0]) $display("FAIL ferr_next got n=%0d exp %0h", got_q.size(), m_q[0]); else passed++;
        total++; if (fe_cnt != 1) $display("FAIL ferr_next_flag got %0d exp 1", fe_cnt); else passed++;
    endtask

    task automatic test_glitch();
        int c;
        clear_mon();
        ready = 1'b1;
        c = cyc;
        rx = 1'b0;
        wait_clk(100);
        rx = 1'b1;
        wait_clk(300);
        total++; if (got_q.size() != 0 || fe_cnt != 0) $display("FAIL glitch_quiet got n=%0d fe=%0d exp 0 0", got_q.size(), fe_cnt); else passed++;
        total++; if (fall_busy < 0 || fall_busy - (c + 1) > 210) $display("FAIL glitch_busy got %0d exp <=210", fall_busy - (c + 1)); else passed++;
    endtask

    task automatic test_mid_reset();
        logic [7:0] b;
        clear_mon();
        ready = 1'b1;
        b = 8'h12;
        rx = 1'b0;
        wait_clk(CPB);
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            wait_clk(CPB);
        end
        rx = b[4];
        wait_clk(CPB / 2);
        total++; if (busy !== 1'b1) $display("FAIL rst_prebusy got %b exp 1", busy); else passed++;
        rst = 1'b0;
        wait_clk(1);
        rst = 1'b1;
        m_valid = 1'b0;
        m_data = 8'h00;
        total++; if ({valid, frame_err, overrun, busy} !== 4'b0) $display("FAIL rst_flags got %b exp 0000", {valid, frame_err, overrun, busy}); else passed++;
        total++; if (data !== m_data) $display("FAIL rst_data got %0h exp %0h", data, m_data); else passed++;
        rx = 1'b1;
        wait_clk(3 * CPB);
        total++; if (got_q.size() != 0 || busy !== 1'b0) $display("FAIL rst_partial got n=%0d b=%b exp 0 0", got_q.size(), busy); else passed++;
        send_frame(8'h12, CPB, 1'b1);
        m_frame(8'h12, 1'b1);
        wait_clk(CPB);
        total++; if (got_q.size() != 1 || got_q[0] !== m_q[0]) $display("FAIL rst_next got n=%0d exp %0h", got_q.size(), m_q[0]); else passed++;
    endtask

    task automatic test_skew();
        int rates [2];
        rates[0] = 408;
        rates[1] = 424;
        for (int k = 0; k < 2; k++) begin
            clear_mon();
            ready = 1'b1;
            send_frame(8'hC3, rates[k], 1'b1);
            m_frame(8'hC3, 1'b1);
            wait_clk(CPB);
            total++; if (got_q.size() != 1 || got_q[0] !== m_q[0] || fe_cnt != 0) $display("FAIL skew_%0d got n=%0d fe=%0d exp %0h", rates[k], got_q.size(), fe_cnt, m_q[0]); else passed++;
        end
    endtask

    task automatic test_random();
        logic [7:0] b;
        logic r;
        int cpb;
        clear_mon();
        for (int k = 0; k < 3; k++) begin
            b = 8'($urandom);
            r = 1'($urandom_range(0, 1));
            cpb = $urandom_range(408, 424);
            ready = r;
            m_set_ready(r);
            send_frame(b, cpb, 1'b1);
            m_frame(b, r);
            wait_clk($urandom_range(1, 200));
        end
        ready = 1'b1;
        m_set_ready(1'b1);
        wait_clk(3);
        total++; if (got_q.size() != m_q.size()) $display("FAIL rand_count got %0d exp %0d", got_q.size(), m_q.size()); else passed++;
        for (int i = 0; i < m_q.size(); i++) begin
            if (i < got_q.size()) begin
                total++; if (got_q[i] !== m_q[i]) $display("FAIL rand_byte%0d got %0h exp %0h", i, got_q[i], m_q[i]); else passed++;
            end
        end
        total++; if (ov_cnt != m_ov || fe_cnt != 0) $display("FAIL rand_flags got ov=%0d fe=%0d exp %0d 0", ov_cnt, fe_cnt, m_ov); else passed++;
    endtask

    initial begin
        wait_clk(1);
        test_reset();
        test_single();
        test_back_to_back();
        test_frame_err();
        test_glitch();
        test_mid_reset();
        test_skew();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver for the board's serial input pin, running in the single 48 MHz HFOSC clock domain.
- Converts the asynchronous rx line into bytes presented on a valid/ready handshake to the user logic instantiated under the board top.
- Paired with the existing transmit path, this completes the host serial link.

Parameters:
CLK_HZ, 48000000, system clock frequency in Hz
BAUD, 115200, line rate in bits/s
CLKS_PER_BIT, CLK_HZ/BAUD (integer division, 416 at defaults), clocks per bit; must be >= 8

Ports:
clk  input  1  system clock (48 MHz HFOSC)
rst  input  1  reset: synchronous, active-low (rst==0 resets on the next clk edge)
rx  input  1  asynchronous serial input; idles high
data  output  8  received byte; stable while valid==1
valid  output  1  data holds an unconsumed byte
ready  input  1  consumer accepts data when valid&&ready
frame_err  output  1  one-cycle pulse: stop bit sampled low
overrun  output  1  one-cycle pulse: new byte overwrote an unconsumed byte
busy  output  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset (rst==0 at clk edge):
  - state=IDLE; both synchronizer flops=1; shift register=0; bit index=0; counter=0.
  - data=0; valid=0; frame_err=0; overrun=0; busy=0.
  - Reset takes priority over everything, including mid-frame. A partial frame is discarded.
- Input sync: rx passes through 2 flops (rx_s). All decisions use rx_s only.
- Counter width: clog2(CLKS_PER_BIT). HALF = CLKS_PER_BIT/2 (integer).
- FSM states:
  - IDLE: rx_s==0 -> START, counter=0.
  - START: counter counts up. At counter==HALF-1, resample rx_s.
    - rx_s==0 -> DATA, counter=0, bit index=0.
    - rx_s==1 -> IDLE (glitch rejected, no flag).
  - DATA: at counter==CLKS_PER_BIT-1, sample rx_s into shift register, LSB first (first data bit ends in data[0]). Counter=0, bit index++. After the 8th sample -> STOP.
  - STOP: at counter==CLKS_PER_BIT-1, sample rx_s (mid stop bit).
    - rx_s==1 -> load byte to output, go to IDLE.
    - rx_s==0 -> frame_err=1 for one cycle, byte discarded, go to WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s==1, then IDLE. This prevents a break (line held low) from retriggering START.
- Every sample point is the bit centre: START decision at HALF clocks, subsequent samples every CLKS_PER_BIT clocks.
- Output handshake, evaluated per cycle:
  - load && valid && !ready: data<=new byte; valid stays 1; overrun=1 for one cycle.
  - load && (!valid || ready): data<=new byte; valid=1; no overrun. This covers consume and load in the same cycle.
  - !load && valid && ready: valid<=0; data retains its last value.
- Latency: valid rises 2 + HALF + 9*CLKS_PER_BIT + 1 clocks after the rx falling edge is registered in the first synchronizer flop.
- frame_err and overrun are single-cycle pulses and are never both asserted with a reset.
- Back-to-back frames:
  - Returning to IDLE at mid stop bit lets a start bit beginning immediately after the nominal stop bit be detected.
  - Required tolerance: ±2% baud mismatch.

Test Plan:
1. Send 0xA5 at 416 clk/bit, ready=1 -> valid high exactly 1 cycle, data=0xA5, frame_err=0, overrun=0. valid edge at the computed latency ±1 clock.
2. Back-to-back 0x00, 0xFF, 0x55, no idle gap, ready=0 -> overrun pulses twice; valid stays 1; final data=0x55. Then raise ready for 1 cycle -> valid=0.
3. Send 0x3C with stop bit driven low, rx held low 2000 cycles, then high -> one frame_err pulse, valid=0, busy=1 until rx_s high. Next frame 0x81 -> data=0x81 valid.
4. Glitch: rx low for 100 cycles (< HALF=208), then high -> no valid, no frame_err; busy falls within 210 cycles of the edge.
5. Assert rst=0 for 1 cycle during DATA bit 4 of 0x12 -> all outputs 0 next cycle; partial byte never appears. Following frame 0x12 received correctly.
6. Baud skew: send 0xC3 with bit periods of 408 and then 424 clocks -> data=0xC3 both times, no frame_err.
